// File: rtl/alu_param.sv
// Parameterised multi-cycle ALU: bit-serial multiply/divide plus single-cycle
// shift, average and error paths, all sequenced by an IDLE/CALC/DONE FSM.
module alu_param #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic [2:0]           mode,
  input  logic [WIDTH-1:0]     in_A,
  input  logic [WIDTH-1:0]     in_B,
  output logic                 busy,
  output logic                 ready,
  output logic                 err,
  output logic [2*WIDTH-1:0]   out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MULU = 3'd0, OP_MULS = 3'd1, OP_DIVU = 3'd2, OP_SHR = 3'd3,
    OP_AVG  = 3'd4, OP_RSV5 = 3'd5, OP_RSV6 = 3'd6, OP_RSV7 = 3'd7
  } op_t;

  state_t           state;
  op_t              mode_q;
  logic             pend;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] opd;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             neg;
  logic [SHW-1:0]   cnt;

  logic               take;
  logic               is_div;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_n;
  logic [WIDTH-1:0]   mul_lo_n;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_hi_n;
  logic [WIDTH-1:0]   div_lo_n;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     avg_sum;

  // Requests are latched on the accept edge and dispatched one edge later.
  assign take   = valid && (((state == IDLE) && !pend) || (state == DONE));
  assign is_div = (mode_q == OP_DIVU);

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], lo[WIDTH-1:1]};
    div_sh   = {hi, lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, opd};
    // The remainder stays below the divisor, so the diff MSB is a clean borrow.
    div_ge   = !div_diff[WIDTH];
    div_hi_n = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_lo_n = {lo[WIDTH-2:0], div_ge};
    prod     = {mul_hi_n, mul_lo_n};
    prod_s   = neg ? -prod : prod;
    abs_a    = a_q[WIDTH-1] ? -a_q : a_q;
    abs_b    = b_q[WIDTH-1] ? -b_q : b_q;
    avg_sum  = {1'b0, a_q} + {1'b0, b_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode_q <= OP_MULU;
      pend   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      opd    <= '0;
      hi     <= '0;
      lo     <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      ready  <= 1'b0;
      err    <= 1'b0;
      out    <= '0;
    end else begin
      ready <= 1'b0;
      if (take) begin
        a_q    <= in_A;
        b_q    <= in_B;
        mode_q <= op_t'(mode);
      end
      case (state)
        IDLE: begin
          if (pend) begin
            pend <= 1'b0;
            busy <= 1'b1;
            cnt  <= '0;
            case (mode_q)
              OP_MULU: begin
                hi    <= '0;
                lo    <= b_q;
                opd   <= a_q;
                neg   <= 1'b0;
                state <= CALC;
              end
              OP_MULS: begin
                // Multiply magnitudes, then negate the full product if signs differ.
                hi    <= '0;
                lo    <= abs_b;
                opd   <= abs_a;
                neg   <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                state <= CALC;
              end
              OP_DIVU: begin
                if (b_q != '0) begin
                  hi    <= '0;
                  lo    <= a_q;
                  opd   <= b_q;
                  neg   <= 1'b0;
                  state <= CALC;
                end else begin
                  out   <= {a_q, {WIDTH{1'b1}}};
                  err   <= 1'b1;
                  ready <= 1'b1;
                  state <= DONE;
                end
              end
              OP_SHR: begin
                out   <= {{WIDTH{1'b0}}, a_q >> b_q[SHW-1:0]};
                err   <= 1'b0;
                ready <= 1'b1;
                state <= DONE;
              end
              OP_AVG: begin
                out   <= {{(WIDTH-1){1'b0}}, avg_sum} >> 1;
                err   <= 1'b0;
                ready <= 1'b1;
                state <= DONE;
              end
              default: begin
                out   <= '0;
                err   <= 1'b1;
                ready <= 1'b1;
                state <= DONE;
              end
            endcase
          end else begin
            pend <= take;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            hi <= div_hi_n;
            lo <= div_lo_n;
          end else begin
            hi <= mul_hi_n;
            lo <= mul_lo_n;
          end
          if (cnt == SHW'(WIDTH-1)) begin
            out   <= is_div ? {div_hi_n, div_lo_n} : prod_s;
            err   <= 1'b0;
            ready <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          pend  <= take;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          pend  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_param.sv
// Scoreboard bench for alu_param at WIDTH=32 and WIDTH=8: a reference model
// queues expected results at accept time, monitors pop them on ready.
`timescale 1ns/1ps
module tb_alu_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        v32, busy32, rdy32, err32;
  logic [2:0]  m32;
  logic [31:0] a32, b32;
  logic [63:0] out32;
  logic        v8, busy8, rdy8, err8;
  logic [2:0]  m8;
  logic [7:0]  a8, b8;
  logic [15:0] out8;

  alu_param #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .valid(v32), .mode(m32), .in_A(a32), .in_B(b32),
    .busy(busy32), .ready(rdy32), .err(err32), .out(out32)
  );
  alu_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .valid(v8), .mode(m8), .in_A(a8), .in_B(b8),
    .busy(busy8), .ready(rdy8), .err(err8), .out(out8)
  );

  typedef struct {
    logic [63:0] out;
    logic        err;
    int unsigned acc;
    int unsigned lat;
    string       tag;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [63:0] last32 = '0;
  logic [63:0] last8  = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input int unsigned w, input logic [2:0] md,
                                 input logic [63:0] ai, input logic [63:0] bi,
                                 input string tag);
    exp_t e;
    logic [63:0] m1, m2, a, b;
    longint sa, sb;
    m1 = (64'd1 << w) - 64'd1;
    m2 = (w == 32) ? '1 : ((64'd1 << (2*w)) - 64'd1);
    a = ai & m1;
    b = bi & m1;
    e.tag = tag; e.err = 1'b0; e.acc = 0; e.lat = 1;
    case (md)
      3'd0: begin e.out = (a * b) & m2; e.lat = w + 1; end
      3'd1: begin
        sa = longint'(a << (64 - w)); sa = sa >>> (64 - w);
        sb = longint'(b << (64 - w)); sb = sb >>> (64 - w);
        e.out = 64'(sa * sb) & m2;
        e.lat = w + 1;
      end
      3'd2: begin
        if (b != 0) begin e.out = ((a % b) << w) | (a / b); e.lat = w + 1; end
        else begin e.out = (a << w) | m1; e.err = 1'b1; end
      end
      3'd3: e.out = a >> (b & 64'(w - 1));
      3'd4: e.out = (a + b) >> 1;
      default: begin e.out = '0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // Caller is aligned just after a negedge; the next posedge is the accept edge.
  task automatic send(input bit w8, input logic [2:0] md, input logic [63:0] a,
                      input logic [63:0] b, input int hold, input string tag);
    exp_t e;
    e = model(w8 ? 8 : 32, md, a, b, tag);
    if (w8) begin v8 = 1'b1; m8 = md; a8 = a[7:0]; b8 = b[7:0]; end
    else begin v32 = 1'b1; m32 = md; a32 = a[31:0]; b32 = b[31:0]; end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 0) begin
        e.acc = cyc;
        if (w8) q8.push_back(e); else q32.push_back(e);
      end
    end
    if (w8) v8 = 1'b0; else v32 = 1'b0;
  endtask

  task automatic drain(input bit w8);
    int n = 0;
    while ((w8 ? q8.size() : q32.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check(w8 ? "timeout8" : "timeout32", 64'(w8 ? q8.size() : q32.size()), 64'd0);
      if (w8) q8.delete(); else q32.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic eb;
    eb = 1'b0;
    if (q32.size() != 0) eb = (cyc >= q32[0].acc + 1);
    check("busy32", 64'(busy32), 64'(eb));
    if (rdy32) begin
      if (q32.size() == 0) check("spurious_ready32", 64'd1, 64'd0);
      else begin
        e = q32.pop_front();
        check({e.tag, "_out"}, out32, e.out);
        check({e.tag, "_err"}, 64'(err32), 64'(e.err));
        check({e.tag, "_lat"}, 64'(cyc - e.acc), 64'(e.lat));
        last32 = e.out;
      end
    end else check("hold32", out32, last32);
  end

  always @(negedge clk) begin
    exp_t e;
    logic eb;
    eb = 1'b0;
    if (q8.size() != 0) eb = (cyc >= q8[0].acc + 1);
    check("busy8", 64'(busy8), 64'(eb));
    if (rdy8) begin
      if (q8.size() == 0) check("spurious_ready8", 64'd1, 64'd0);
      else begin
        e = q8.pop_front();
        check({e.tag, "_out"}, 64'(out8), e.out);
        check({e.tag, "_err"}, 64'(err8), 64'(e.err));
        check({e.tag, "_lat"}, 64'(cyc - e.acc), 64'(e.lat));
        last8 = e.out;
      end
    end else check("hold8", 64'(out8), last8);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b1;
    v32 = 1'b0; m32 = '0; a32 = '0; b32 = '0;
    v8  = 1'b0; m8  = '0; a8  = '0; b8  = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out32", out32, 64'd0);
    check("rst_busy32", 64'(busy32), 64'd0);
    check("rst_ready32", 64'(rdy32), 64'd0);
    check("rst_err32", 64'(err32), 64'd0);
    check("rst_out8", 64'(out8), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(0, 3'd1, 64'hFFFFFFFE, 64'h3, 1, "muls_m2x3");           drain(0);
    send(0, 3'd2, 64'd100, 64'd7, 1, "divu_100_7");                drain(0);
    send(0, 3'd2, 64'h1234, 64'h0, 1, "divu_by0");                 drain(0);
    send(0, 3'd4, 64'hFFFFFFFF, 64'hFFFFFFFF, 1, "avg_max");       drain(0);
    send(0, 3'd3, 64'h80000000, 64'h25, 1, "shr_25");              drain(0);
    send(0, 3'd3, 64'hA5A5A5A5, 64'h1F, 1, "shr_31");              drain(0);
    send(0, 3'd1, 64'h80000000, 64'h80000000, 1, "muls_minmin");   drain(0);
    send(0, 3'd1, 64'h7FFFFFFF, 64'h80000000, 1, "muls_maxmin");   drain(0);
    send(0, 3'd0, 64'hFFFFFFFF, 64'hFFFFFFFF, 1, "mulu_max");      drain(0);
    for (int i = 0; i < 3; i++) begin
      send(0, 3'd0, 64'($urandom), 64'($urandom), 1, "mulu_rnd");  drain(0);
      send(0, 3'd1, 64'($urandom), 64'($urandom), 1, "muls_rnd");  drain(0);
      send(0, 3'd2, 64'($urandom), 64'($urandom >> $urandom_range(0, 28)), 1, "divu_rnd");
      drain(0);
      send(0, 3'd4, 64'($urandom), 64'($urandom), 1, "avg_rnd");   drain(0);
    end
    for (int md = 5; md < 8; md++) begin
      send(0, 3'(md), 64'h1111, 64'h2222, 1, "reserved");          drain(0);
    end

    // Held valid during a MULU must yield a single completion.
    send(0, 3'd0, 64'h1234, 64'h5678, 5, "mulu_hold5");            drain(0);

    // Back-to-back: valid presented only at the DONE-exit edge.
    send(0, 3'd0, 64'($urandom), 64'($urandom), 1, "b2b_mulu");
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy32 && n < 100);
    if (!rdy32) check("b2b_wait", 64'(rdy32), 64'd1);
    send(0, 3'd3, 64'hF0000000, 64'h4, 1, "b2b_shr");              drain(0);

    // Asynchronous reset in the middle of a DIVU.
    send(0, 3'd2, 64'hDEADBEEF, 64'h1357, 1, "divu_abort");
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    q32.delete(); q8.delete();
    last32 = '0; last8 = '0;
    #1;
    check("abort_out32", out32, 64'd0);
    check("abort_busy32", 64'(busy32), 64'd0);
    check("abort_ready32", 64'(rdy32), 64'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(0, 3'd2, 64'hDEADBEEF, 64'h1357, 1, "divu_after");        drain(0);

    send(1, 3'd1, 64'h80, 64'h80, 1, "w8_muls_minmin");            drain(1);
    send(1, 3'd2, 64'hFF, 64'h10, 1, "w8_divu");                   drain(1);
    send(1, 3'd0, 64'hFF, 64'hFF, 1, "w8_mulu_max");               drain(1);
    send(1, 3'd1, 64'h7F, 64'h80, 1, "w8_muls_maxmin");            drain(1);
    send(1, 3'd2, 64'h5A, 64'h00, 1, "w8_divu_by0");               drain(1);
    send(1, 3'd3, 64'h80, 64'h0B, 1, "w8_shr");                    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
